// File: rtl/system_pio_pkg.sv
// Shared definitions for the PIO serial output path: FSM states and the default
// PIO out_port width.
package system_pio_pkg;

    localparam int unsigned PIO_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } state_t;

endpackage

// File: rtl/system_pio_clk_div.sv
// Free-running divider producing a one-cycle tick every CLK_DIV clocks; clear
// restarts the count so the next tick lands CLK_DIV cycles after a state entry.
module system_pio_clk_div #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CNT_W = $clog2(CLK_DIV) + 1;

    logic [CNT_W-1:0] count;

    assign tick = (count == CNT_W'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear || tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/system_pio_shift_out.sv
// Serialises the PIO out_port onto a 74HC595-style chain (sclk/sdata/latch),
// sending on change, on force_update, and once after reset.
module system_pio_shift_out
    import system_pio_pkg::*;
#(
    parameter int unsigned WIDTH     = PIO_WIDTH,
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             force_update,
    output logic             sclk,
    output logic             sdata,
    output logic             latch,
    output logic             busy
);

    localparam int unsigned BIT_W = $clog2(WIDTH) + 1;

    state_t           state, state_next;
    logic [WIDTH-1:0] shreg, shreg_next, shreg_shifted;
    logic [WIDTH-1:0] snapshot, snapshot_next;
    logic [WIDTH-1:0] last_sent, last_sent_next;
    logic             pending, pending_next;
    logic [BIT_W-1:0] bit_cnt, bit_cnt_next;
    logic             sclk_next, sdata_next, latch_next, busy_next;
    logic             tick, div_clear;

    function automatic logic lead_bit(input logic [WIDTH-1:0] v);
        return (MSB_FIRST != 0) ? v[WIDTH-1] : v[0];
    endfunction

    system_pio_clk_div #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_div (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (div_clear),
        .tick   (tick)
    );

    always_comb begin
        if (MSB_FIRST != 0) begin
            shreg_shifted = {shreg[WIDTH-2:0], 1'b0};
        end else begin
            shreg_shifted = {1'b0, shreg[WIDTH-1:1]};
        end
    end

    always_comb begin
        state_next     = state;
        shreg_next     = shreg;
        snapshot_next  = snapshot;
        last_sent_next = last_sent;
        pending_next   = pending;
        bit_cnt_next   = bit_cnt;
        sclk_next      = sclk;
        sdata_next     = sdata;
        latch_next     = latch;
        busy_next      = busy;

        case (state)
            ST_IDLE: begin
                if (pending || force_update || (data_in != last_sent)) begin
                    shreg_next    = data_in;
                    snapshot_next = data_in;
                    pending_next  = 1'b0;
                    state_next    = ST_SHIFT;
                    busy_next     = 1'b1;
                    sclk_next     = 1'b0;
                    sdata_next    = lead_bit(data_in);
                end
            end
            ST_SHIFT: begin
                if (force_update) begin
                    pending_next = 1'b1;
                end
                if (tick) begin
                    if (!sclk) begin
                        sclk_next = 1'b1;
                    end else begin
                        sclk_next = 1'b0;
                        if (bit_cnt == BIT_W'(WIDTH - 1)) begin
                            state_next = ST_LATCH;
                            latch_next = 1'b1;
                        end else begin
                            shreg_next   = shreg_shifted;
                            sdata_next   = lead_bit(shreg_shifted);
                            bit_cnt_next = bit_cnt + 1'b1;
                        end
                    end
                end
            end
            ST_LATCH: begin
                if (force_update) begin
                    pending_next = 1'b1;
                end
                if (tick) begin
                    latch_next     = 1'b0;
                    busy_next      = 1'b0;
                    last_sent_next = snapshot;
                    state_next     = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Both counters restart on any state change.
        div_clear = (state_next != state);
        if (div_clear) begin
            bit_cnt_next = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            shreg     <= '0;
            snapshot  <= '0;
            last_sent <= '0;
            pending   <= 1'b1;
            bit_cnt   <= '0;
            sclk      <= 1'b0;
            sdata     <= 1'b0;
            latch     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            shreg     <= shreg_next;
            snapshot  <= snapshot_next;
            last_sent <= last_sent_next;
            pending   <= pending_next;
            bit_cnt   <= bit_cnt_next;
            sclk      <= sclk_next;
            sdata     <= sdata_next;
            latch     <= latch_next;
            busy      <= busy_next;
        end
    end

endmodule

// File: tb/tb_system_pio_shift_out.sv
// Bench for system_pio_shift_out: a 74HC595 chain model reconstructs each frame and
// is compared with frames predicted from the send-on-change/force/coalesce rules.
module tb_system_pio_shift_out;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a = 1'b0, force_a = 1'b0;
    logic [7:0] data_a = 8'h00;
    logic       sclk_a, sdata_a, latch_a, busy_a;
    logic       rst_b = 1'b0, force_b = 1'b0;
    logic [7:0] data_b = 8'h80;
    logic       sclk_b, sdata_b, latch_b, busy_b;

    system_pio_shift_out #(.WIDTH(8), .CLK_DIV(4), .MSB_FIRST(1)) dut_a (
        .clk(clk), .reset_n(rst_a), .data_in(data_a), .force_update(force_a),
        .sclk(sclk_a), .sdata(sdata_a), .latch(latch_a), .busy(busy_a)
    );

    system_pio_shift_out #(.WIDTH(8), .CLK_DIV(1), .MSB_FIRST(0)) dut_b (
        .clk(clk), .reset_n(rst_b), .data_in(data_b), .force_update(force_b),
        .sclk(sclk_b), .sdata(sdata_b), .latch(latch_b), .busy(busy_b)
    );

    int total = 0;
    int bad   = 0;

    // Chain model / monitor for each DUT, sampled on the falling clock edge.
    logic       p_sclk_a = 0, p_sdata_a = 0, p_latch_a = 0, p_busy_a = 0;
    logic [7:0] chain_a = '0, chain_out_a = '0;
    logic [7:0] got_a[$];
    int rises_a = 0, frame_rises_a = 0, bcnt_a = 0, busy_len_a = 0;
    int lwc_a = 0, latch_w_a = 0, overlap_a = 0, sdv_a = 0;

    logic       p_sclk_b = 0, p_sdata_b = 0, p_latch_b = 0, p_busy_b = 0;
    logic [7:0] chain_b = '0, chain_out_b = '0;
    logic [7:0] got_b[$];
    logic       last_bit_b = 0;
    int rises_b = 0, frame_rises_b = 0, bcnt_b = 0, busy_len_b = 0;
    int lwc_b = 0, latch_w_b = 0, overlap_b = 0, sdv_b = 0;

    always @(negedge clk) begin
        if (busy_a) begin
            if (!p_busy_a) begin rises_a = 0; bcnt_a = 0; end
            bcnt_a++;
        end else if (p_busy_a) begin
            busy_len_a = bcnt_a;
        end
        if (sclk_a && !p_sclk_a) begin chain_a = {chain_a[6:0], sdata_a}; rises_a++; end
        if (sclk_a && (sdata_a !== p_sdata_a)) sdv_a++;
        if (sclk_a && latch_a) overlap_a++;
        if (latch_a && !p_latch_a) begin chain_out_a = chain_a; lwc_a = 0; end
        if (latch_a) lwc_a++;
        if (!latch_a && p_latch_a) begin
            got_a.push_back(chain_out_a); latch_w_a = lwc_a; frame_rises_a = rises_a;
        end
        p_sclk_a = sclk_a; p_sdata_a = sdata_a; p_latch_a = latch_a; p_busy_a = busy_a;
    end

    always @(negedge clk) begin
        if (busy_b) begin
            if (!p_busy_b) begin rises_b = 0; bcnt_b = 0; end
            bcnt_b++;
        end else if (p_busy_b) begin
            busy_len_b = bcnt_b;
        end
        if (sclk_b && !p_sclk_b) begin
            chain_b = {chain_b[6:0], sdata_b}; rises_b++; last_bit_b = sdata_b;
        end
        if (sclk_b && (sdata_b !== p_sdata_b)) sdv_b++;
        if (sclk_b && latch_b) overlap_b++;
        if (latch_b && !p_latch_b) begin chain_out_b = chain_b; lwc_b = 0; end
        if (latch_b) lwc_b++;
        if (!latch_b && p_latch_b) begin
            got_b.push_back(chain_out_b); latch_w_b = lwc_b; frame_rises_b = rises_b;
        end
        p_sclk_b = sclk_b; p_sdata_b = sdata_b; p_latch_b = latch_b; p_busy_b = busy_b;
    end

    // Expected frames derived from the transfer rules.
    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];
    logic [7:0] last_a = '0, last_b = '0;

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    task automatic wait_quiet(input bit sel_b);
        int idle = 0;
        for (int c = 0; c < 3000 && idle < 4; c++) begin
            @(negedge clk);
            if ((sel_b ? busy_b : busy_a) == 1'b0) idle++;
            else idle = 0;
        end
        total++;
        if (idle < 4) begin
            bad++;
            $display("FAIL wait_quiet: idle cycles=%0d required 4 (timeout)", idle);
        end
    endtask

    task automatic wait_latch_a();
        int c = 0;
        while (!latch_a && c < 200) begin @(negedge clk); c++; end
        total++;
        if (latch_a !== 1'b1) begin bad++; $display("FAIL wait_latch: latch=%b required 1", latch_a); end
    endtask

    task automatic pulse_force_a();
        @(posedge clk); #1 force_a = 1'b1;
        @(posedge clk); #1 force_a = 1'b0;
    endtask

    task automatic test_reset();
        rst_a = 1'b0; data_a = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({sclk_a, sdata_a, latch_a, busy_a} !== 4'b0000) begin
            bad++; $display("FAIL reset_outputs: got %b required 0000", {sclk_a, sdata_a, latch_a, busy_a});
        end
        got_a.delete(); exp_a.delete();
        @(posedge clk); #1 rst_a = 1'b1;
        exp_a.push_back(8'h00); last_a = 8'h00;
        wait_quiet(0);
        total++;
        if (got_a.size() !== 1) begin bad++; $display("FAIL reset_frames: got %0d required 1", got_a.size()); end
        else begin
            total++;
            if (got_a[0] !== 8'h00) begin bad++; $display("FAIL reset_value: got %h required 00", got_a[0]); end
        end
        total++;
        if (busy_len_a !== 68) begin bad++; $display("FAIL reset_busy_len: got %0d required 68", busy_len_a); end
        total++;
        if (frame_rises_a !== 8) begin bad++; $display("FAIL reset_sclk_rises: got %0d required 8", frame_rises_a); end
        total++;
        if (latch_w_a !== 4) begin bad++; $display("FAIL reset_latch_width: got %0d required 4", latch_w_a); end
    endtask

    task automatic test_pattern();
        logic [7:0] v;
        for (int i = 0; i < 7; i++) begin
            if (i == 0) v = 8'hA5;
            else if (i == 4) v = last_a;
            else v = 8'($urandom);
            got_a.delete(); exp_a.delete();
            if (v != last_a) exp_a.push_back(v);
            last_a = v;
            @(posedge clk); #1 data_a = v;
            wait_quiet(0);
            total++;
            if (got_a.size() !== exp_a.size()) begin
                bad++; $display("FAIL pattern_count[%0d]: got %0d frames required %0d", i, got_a.size(), exp_a.size());
            end
            for (int k = 0; k < exp_a.size() && k < got_a.size(); k++) begin
                total++;
                if (got_a[k] !== exp_a[k]) begin
                    bad++; $display("FAIL pattern_value[%0d]: chain got %h required %h", i, got_a[k], exp_a[k]);
                end
            end
            if (exp_a.size() == 1) begin
                total++;
                if (busy_len_a !== 68) begin bad++; $display("FAIL pattern_busy_len[%0d]: got %0d required 68", i, busy_len_a); end
            end
        end
    endtask

    task automatic test_coalesce();
        logic [7:0] a, b, c;
        for (int i = 0; i < 3; i++) begin
            if (i == 0) begin a = 8'h01; b = 8'h02; c = 8'h03; end
            else begin
                a = last_a ^ 8'h5A; b = 8'($urandom);
                c = (i == 2) ? a : (a ^ 8'h81);
            end
            got_a.delete(); exp_a.delete();
            exp_a.push_back(a);
            if (c != a) exp_a.push_back(c);
            last_a = c;
            @(posedge clk); #1 data_a = a;
            repeat (14) @(posedge clk);
            #1 data_a = b;
            repeat (12) @(posedge clk);
            #1 data_a = c;
            wait_quiet(0);
            total++;
            if (got_a.size() !== exp_a.size()) begin
                bad++; $display("FAIL coalesce_count[%0d]: got %0d frames required %0d", i, got_a.size(), exp_a.size());
            end
            for (int k = 0; k < exp_a.size() && k < got_a.size(); k++) begin
                total++;
                if (got_a[k] !== exp_a[k]) begin
                    bad++; $display("FAIL coalesce_value[%0d.%0d]: got %h required %h", i, k, got_a[k], exp_a[k]);
                end
            end
        end
    endtask

    task automatic test_force();
        got_a.delete(); exp_a.delete();
        if (last_a != 8'h3C) exp_a.push_back(8'h3C);
        last_a = 8'h3C;
        @(posedge clk); #1 data_a = 8'h3C;
        wait_quiet(0);
        pulse_force_a();
        exp_a.push_back(8'h3C);
        wait_quiet(0);
        pulse_force_a();
        wait_latch_a();
        pulse_force_a();
        exp_a.push_back(8'h3C); exp_a.push_back(8'h3C);
        wait_quiet(0);
        @(posedge clk); #1 data_a = 8'hC3; force_a = 1'b1;
        @(posedge clk); #1 force_a = 1'b0;
        exp_a.push_back(8'hC3); last_a = 8'hC3;
        wait_quiet(0);
        total++;
        if (got_a.size() !== exp_a.size()) begin
            bad++; $display("FAIL force_count: got %0d frames required %0d", got_a.size(), exp_a.size());
        end
        for (int k = 0; k < exp_a.size() && k < got_a.size(); k++) begin
            total++;
            if (got_a[k] !== exp_a[k]) begin bad++; $display("FAIL force_value[%0d]: got %h required %h", k, got_a[k], exp_a[k]); end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] v;
        int c = 0;
        v = last_a ^ 8'hFF;
        got_a.delete(); exp_a.delete();
        @(posedge clk); #1 data_a = v;
        do begin @(negedge clk); c++; end while (!(busy_a && rises_a >= 5) && c < 200);
        #1 rst_a = 1'b0;
        #1;
        total++;
        if ({sclk_a, sdata_a, latch_a, busy_a} !== 4'b0000) begin
            bad++; $display("FAIL midreset_outputs: got %b required 0000", {sclk_a, sdata_a, latch_a, busy_a});
        end
        repeat (3) @(posedge clk);
        #1 rst_a = 1'b1;
        exp_a.push_back(v); last_a = v;
        wait_quiet(0);
        total++;
        if (got_a.size() !== 1) begin bad++; $display("FAIL midreset_count: got %0d frames required 1", got_a.size()); end
        else begin
            total++;
            if (got_a[0] !== v) begin bad++; $display("FAIL midreset_value: got %h required %h", got_a[0], v); end
        end
        total++;
        if (frame_rises_a !== 8) begin bad++; $display("FAIL midreset_rises: got %0d required 8", frame_rises_a); end
        total++;
        if ({overlap_a, sdv_a} !== {32'd0, 32'd0}) begin
            bad++; $display("FAIL a_pin_rules: overlap=%0d sdata_changes_high=%0d required 0/0", overlap_a, sdv_a);
        end
    endtask

    task automatic test_div1();
        logic [7:0] v;
        got_b.delete(); exp_b.delete();
        data_b = 8'h80;
        @(posedge clk); #1 rst_b = 1'b1;
        exp_b.push_back(rev8(8'h80)); last_b = 8'h80;
        wait_quiet(1);
        total++;
        if (busy_len_b !== 17) begin bad++; $display("FAIL div1_busy_len: got %0d required 17", busy_len_b); end
        total++;
        if (last_bit_b !== 1'b1) begin bad++; $display("FAIL div1_last_bit: got %b required 1", last_bit_b); end
        total++;
        if (latch_w_b !== 1) begin bad++; $display("FAIL div1_latch_width: got %0d required 1", latch_w_b); end
        total++;
        if (frame_rises_b !== 8) begin bad++; $display("FAIL div1_rises: got %0d required 8", frame_rises_b); end
        for (int i = 0; i < 4; i++) begin
            v = 8'($urandom);
            if (v != last_b) exp_b.push_back(rev8(v));
            last_b = v;
            @(posedge clk); #1 data_b = v;
            wait_quiet(1);
        end
        total++;
        if (got_b.size() !== exp_b.size()) begin
            bad++; $display("FAIL div1_count: got %0d frames required %0d", got_b.size(), exp_b.size());
        end
        for (int k = 0; k < exp_b.size() && k < got_b.size(); k++) begin
            total++;
            if (got_b[k] !== exp_b[k]) begin bad++; $display("FAIL div1_value[%0d]: chain got %h required %h", k, got_b[k], exp_b[k]); end
        end
        total++;
        if ({overlap_b, sdv_b} !== {32'd0, 32'd0}) begin
            bad++; $display("FAIL b_pin_rules: overlap=%0d sdata_changes_high=%0d required 0/0", overlap_b, sdv_b);
        end
    endtask

    initial begin
        test_reset();
        test_pattern();
        test_coalesce();
        test_force();
        test_reset_mid();
        test_div1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, bench incomplete");
        $fatal(1, "watchdog");
    end

endmodule
